// File: rtl/imem_uart_loader.sv
// UART program loader: receives 8N1 bytes, packs them big-endian into 32-bit words
// and writes them sequentially into instruction memory while holding the CPU in reset.
module imem_uart_loader #(
   parameter int CLKS_PER_BIT = 434,
   parameter int ADDR_W       = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rx,
   input  logic              load_en,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_hold,
   output logic [15:0]       word_count,
   output logic              frame_err
);

   // state | meaning
   // IDLE  | line idle, waiting for a falling edge on synced rx
   // START | timing to the middle of the start bit, rejecting glitches
   // DATA  | sampling 8 data bits LSB first, one per bit period
   // STOP  | sampling the stop bit; high = byte valid, low = framing error
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

   localparam int TMR_W = $clog2(CLKS_PER_BIT);
   localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT / 2 - 1);

   rx_state_t        state, state_nxt;
   logic [TMR_W-1:0] tmr, tmr_nxt;
   logic [2:0]       bit_idx, bit_nxt;
   logic [7:0]       shift, shift_nxt;
   logic             byte_ok, byte_bad;

   logic             rx_meta, rx_sync;
   logic             load_en_q;
   logic [1:0]       byte_cnt;
   logic [23:0]      word_buf;
   logic             load_rise;

   assign load_rise = load_en & ~load_en_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         state   <= IDLE;
         tmr     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         state   <= state_nxt;
         tmr     <= tmr_nxt;
         bit_idx <= bit_nxt;
         shift   <= shift_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr + TMR_W'(1);
      bit_nxt   = bit_idx;
      shift_nxt = shift;
      byte_ok   = 1'b0;
      byte_bad  = 1'b0;
      if (!load_en) begin
         state_nxt = IDLE;
         tmr_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               tmr_nxt = '0;
               if (!rx_sync) state_nxt = START;
            end
            START: begin
               if (tmr == TMR_HALF) begin
                  tmr_nxt   = '0;
                  bit_nxt   = '0;
                  state_nxt = rx_sync ? IDLE : DATA;
               end
            end
            DATA: begin
               if (tmr == TMR_FULL) begin
                  tmr_nxt            = '0;
                  shift_nxt[bit_idx] = rx_sync;
                  bit_nxt            = bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state_nxt = STOP;
               end
            end
            STOP: begin
               if (tmr == TMR_FULL) begin
                  tmr_nxt   = '0;
                  state_nxt = IDLE;
                  byte_ok   = rx_sync;
                  byte_bad  = ~rx_sync;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Word packing and the write port; the address bump lands the cycle after the strobe.
   always_ff @(posedge clock) begin
      if (!reset) begin
         load_en_q  <= 1'b0;
         byte_cnt   <= '0;
         word_buf   <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         word_count <= '0;
         frame_err  <= 1'b0;
         cpu_hold   <= 1'b0;
      end else begin
         load_en_q <= load_en;
         wr_en     <= 1'b0;
         cpu_hold  <= load_en | (byte_cnt != 2'd0) | wr_en;

         if (wr_en) begin
            wr_addr <= wr_addr + ADDR_W'(4);
            if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
         end

         if (!load_en) begin
            byte_cnt <= '0;
         end else if (byte_bad) begin
            frame_err <= 1'b1;
            byte_cnt  <= '0;
         end else if (byte_ok) begin
            word_buf <= {word_buf[15:0], shift};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
               wr_en   <= 1'b1;
               wr_data <= {word_buf, shift};
            end
         end

         if (load_rise) begin
            wr_addr    <= '0;
            word_count <= '0;
            frame_err  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: UART byte driver, write scoreboard and
// a monitor that checks every write strobe against the expected queue.
module tb_imem_uart_loader;

   localparam int CPB = 8;
   localparam int AW  = 10;

   logic          clock = 1'b0;
   logic          reset;
   logic          rx;
   logic          load_en;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;
   logic          cpu_hold;
   logic [15:0]   word_count;
   logic          frame_err;

   int checks = 0;
   int errors = 0;
   int writes = 0;
   logic wr_en_prev = 1'b0;
   logic [AW+31:0] sb[$];

   imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
      .clock      (clock),
      .reset      (reset),
      .rx         (rx),
      .load_en    (load_en),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .cpu_hold   (cpu_hold),
      .word_count (word_count),
      .frame_err  (frame_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clock);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clock);
      rx = 1'b1;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24], 1'b1);
      send_byte(w[23:16], 1'b1);
      send_byte(w[15:8],  1'b1);
      send_byte(w[7:0],   1'b1);
   endtask

   task automatic expect_word(input logic [AW-1:0] a, input logic [31:0] w);
      sb.push_back({a, w});
      send_word(w);
      repeat (4) @(negedge clock);
   endtask

   // Monitor: every strobe must match the head of the scoreboard and last one cycle.
   always @(negedge clock) begin
      logic [AW+31:0] e;
      if (wr_en === 1'b1) begin
         writes++;
         chk("wr_en_width", {31'b0, wr_en_prev}, 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected_write", {31'b0, wr_en}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("wr_addr", {22'b0, wr_addr}, {22'b0, e[AW+31:32]});
            chk("wr_data", wr_data, e[31:0]);
         end
      end
      wr_en_prev = wr_en;
   end

   initial begin
      reset = 1'b0; load_en = 1'b0; rx = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b1;

      // 1: reset state, then idle line with loader enabled
      chk("rst_wr_en",      {31'b0, wr_en}, 32'd0);
      chk("rst_wr_addr",    {22'b0, wr_addr}, 32'd0);
      chk("rst_wr_data",    wr_data, 32'd0);
      chk("rst_cpu_hold",   {31'b0, cpu_hold}, 32'd0);
      chk("rst_word_count", {16'b0, word_count}, 32'd0);
      chk("rst_frame_err",  {31'b0, frame_err}, 32'd0);
      load_en = 1'b1;
      repeat (3) @(negedge clock);
      chk("idle_cpu_hold",  {31'b0, cpu_hold}, 32'd1);
      repeat (1000) @(negedge clock);
      chk("idle_no_write",  writes, 0);

      // 2: single word
      expect_word(10'd0, 32'h8C020004);
      chk("t2_wr_addr",    {22'b0, wr_addr}, 32'd4);
      chk("t2_word_count", {16'b0, word_count}, 32'd1);
      chk("t2_writes",     writes, 1);

      // 3: reload, three back-to-back words, then release the CPU
      load_en = 1'b0;
      repeat (3) @(negedge clock);
      load_en = 1'b1;
      repeat (2) @(negedge clock);
      chk("t3_addr_clr",   {22'b0, wr_addr}, 32'd0);
      chk("t3_count_clr",  {16'b0, word_count}, 32'd0);
      sb.push_back({10'd0, 32'h01020304});
      sb.push_back({10'd4, 32'hA0B0C0D0});
      sb.push_back({10'd8, 32'h12345678});
      send_word(32'h01020304);
      send_word(32'hA0B0C0D0);
      send_word(32'h12345678);
      repeat (4) @(negedge clock);
      chk("t3_word_count", {16'b0, word_count}, 32'd3);
      chk("t3_wr_addr",    {22'b0, wr_addr}, 32'd12);
      chk("t3_hold_on",    {31'b0, cpu_hold}, 32'd1);
      load_en = 1'b0;
      @(negedge clock);
      chk("t3_hold_off",   {31'b0, cpu_hold}, 32'd0);

      // 4: framing error followed by a clean word
      load_en = 1'b1;
      repeat (2) @(negedge clock);
      send_byte(8'hA5, 1'b0);
      repeat (16) @(negedge clock);
      chk("t4_frame_err",  {31'b0, frame_err}, 32'd1);
      expect_word(10'd0, 32'h11223344);
      chk("t4_word_count", {16'b0, word_count}, 32'd1);

      // 5: start-bit glitch must not produce a byte
      rx = 1'b0;
      repeat (2) @(negedge clock);
      rx = 1'b1;
      repeat (100) @(negedge clock);
      chk("t5_byte_cnt",   {30'b0, dut.byte_cnt}, 32'd0);
      expect_word(10'd4, 32'hDEADBEEF);
      chk("t5_wr_addr",    {22'b0, wr_addr}, 32'd8);

      // 6: address wrap, then reset mid-word
      dut.wr_addr = 10'd1020;
      @(negedge clock);
      expect_word(10'd1020, 32'hCAFEF00D);
      chk("t6_wrap_addr",  {22'b0, wr_addr}, 32'd0);
      chk("t6_word_count", {16'b0, word_count}, 32'd3);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      chk("t6_byte_cnt",   {30'b0, dut.byte_cnt}, 32'd0);
      chk("t6_frame_clr",  {31'b0, frame_err}, 32'd0);
      chk("t6_count_clr",  {16'b0, word_count}, 32'd0);
      repeat (500) @(negedge clock);
      chk("t6_wr_addr",    {22'b0, wr_addr}, 32'd0);
      chk("pending_writes", sb.size(), 0);
      chk("total_writes",  writes, 7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
